// File: rtl/sfifo_rd_stage.sv
// sfifo_rd_stage: read-side adapter between an sfifo with fixed read latency and
// a valid/ready consumer. Reads are issued only when the skid buffer is guaranteed
// to have room for every in-flight word, so the consumer can stall freely.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst        - asynchronous active-low reset
//   en         - permits issuing new fifo reads (in-flight reads always complete)
//   fifo_empty - sfifo empty flag
//   fifo_dout  - sfifo read data, valid RD_LAT cycles after the read strobe
//   fifo_udfl  - sfifo underflow flag
//   fifo_rd    - read strobe to sfifo (combinational)
//   dout       - head-of-buffer word (combinational from registered state)
//   dout_vld   - dout holds a valid word
//   dout_rdy   - consumer accepts dout this cycle
//   pop_cnt    - wrapping count of words delivered to the consumer
//   err        - sticky error: underflow seen or skid buffer overrun
module sfifo_rd_stage #(
    parameter int unsigned DW        = 16,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_udfl,
    output logic          fifo_rd,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic [15:0]   pop_cnt,
    output logic          err
);

    localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // counters must represent 0..BUF_DEPTH inclusive
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [CW-1:0]     occ;
    logic [CW-1:0]     inflight;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [RD_LAT-1:0] rd_pipe;
    logic [DW-1:0]     mem [BUF_DEPTH];

    logic credit_ok;
    logic capture;
    logic pop;
    logic full;
    logic drop;
    logic wr;

    // Credit check counts in-flight words as already occupying the buffer.
    // Held low during reset so no word is popped from the sfifo and lost.
    assign credit_ok = (SW'(occ) + SW'(inflight)) < SW'(BUF_DEPTH);
    assign fifo_rd   = rst & en & ~fifo_empty & credit_ok;

    assign capture  = rd_pipe[RD_LAT-1];
    assign dout_vld = (occ != '0);
    assign dout     = mem[rptr];
    assign pop      = dout_vld & dout_rdy;
    assign full     = (occ == CW'(BUF_DEPTH));
    // a capture into a full buffer is only survivable if the head leaves this cycle
    assign drop     = capture & full & ~pop;
    assign wr       = capture & ~drop;

    // Strobe delay line: last stage marks the cycle fifo_dout carries the word.
    generate
        if (RD_LAT == 1) begin : g_pipe1
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) rd_pipe <= '0;
                else      rd_pipe <= fifo_rd;
            end
        end else begin : g_pipen
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) rd_pipe <= '0;
                else      rd_pipe <= {rd_pipe[RD_LAT-2:0], fifo_rd};
            end
        end
    endgenerate

    // Occupancy, in-flight count and buffer pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ      <= '0;
            inflight <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            case ({wr, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
            case ({fifo_rd, capture})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            if (wr)  wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
        end
    end

    // Skid buffer storage; contents are don't-care while occ says empty.
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= fifo_dout;
    end

    // Delivered-word counter and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (pop)              pop_cnt <= pop_cnt + 16'd1;
            if (fifo_udfl | drop) err     <= 1'b1;
        end
    end

endmodule

// File: doc/sfifo_rd_stage.md
SFIFO_RD_STAGE -- requirements
Module: sfifo_rd_stage

Interface
REQ-001 Parameter DW, default 16, data width matching the sfifo data path.
REQ-002 Parameter RD_LAT, default 1, clock cycles from the posedge that samples fifo_rd=1 to the posedge at which fifo_dout holds the popped word; legal range 1-3.
REQ-003 Parameter BUF_DEPTH, default 4, number of entries in the output skid buffer; power of two, minimum RD_LAT+1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  high permits issuing new FIFO reads; low blocks new reads only.
REQ-007 fifo_empty  input  1  sfifo empty flag.
REQ-008 fifo_dout  input  DW  sfifo read data.
REQ-009 fifo_udfl  input  1  sfifo underflow flag.
REQ-010 fifo_rd  output  1  read strobe to sfifo rd_in.
REQ-011 dout  output  DW  head-of-buffer data to the consumer.
REQ-012 dout_vld  output  1  dout holds a valid word.
REQ-013 dout_rdy  input  1  consumer accepts dout this cycle.
REQ-014 pop_cnt  output  16  count of words delivered to the consumer.
REQ-015 err  output  1  sticky error flag.

Function
REQ-016 Track the number of in-flight reads (issued but not yet captured) as inflight, and the number of buffered words as occ; both are registered.
REQ-017 fifo_rd is combinational: en & ~fifo_empty & (occ + inflight < BUF_DEPTH); no look-ahead credit from a same-cycle pop.
REQ-018 An RD_LAT-stage shift register carries each issued strobe; when its last stage is 1 at a posedge, capture fifo_dout into buf[wptr], advance wptr modulo BUF_DEPTH, and decrement inflight.
REQ-019 dout = buf[rptr], combinational from registered state; dout_vld = (occ != 0).
REQ-020 Pop occurs at a posedge where dout_vld & dout_rdy; rptr advances modulo BUF_DEPTH and occ decrements.
REQ-021 Capture and pop in the same cycle leave occ unchanged; issue and capture in the same cycle leave inflight unchanged.
REQ-022 Words are delivered in issue order with no loss or duplication; dout stays stable while dout_vld=1 and dout_rdy=0.
REQ-023 en=0 stops new issues only; reads already in flight are still captured and delivered.
REQ-024 pop_cnt increments by 1 per pop and wraps from 0xFFFF to 0x0000.
REQ-025 err sets when fifo_udfl=1 at a posedge, or when a capture occurs with occ=BUF_DEPTH and no same-cycle pop; in that overflow case the word is dropped and occ stays at BUF_DEPTH.
REQ-026 err clears only on reset.
REQ-027 With RD_LAT=1, BUF_DEPTH=4, a non-empty FIFO and dout_rdy held high, sustained throughput is one word per clock after a fill latency of RD_LAT+1 cycles.

Reset
REQ-028 While rst=0, the following hold asynchronously: occ=0, inflight=0, wptr=0, rptr=0, delay stages=0, pop_cnt=0, err=0; hence fifo_rd=0 and dout_vld=0.
REQ-029 Reset asserted mid-operation discards buffered and in-flight words; after rst rises, no capture occurs for any pre-reset strobe.
REQ-030 The first fifo_rd may assert in the first cycle after rst deasserts.

Verification
REQ-031 Single word: FIFO holds 0x1234, en=1, dout_rdy=1 -> fifo_rd high for 1 cycle, dout_vld=1 with dout=0x1234 RD_LAT+1 cycles later, pop_cnt=1.
REQ-032 Backpressure: FIFO holds 0x0001..0x0008, dout_rdy=0 -> exactly 4 fifo_rd pulses, dout=0x0001 held stable; after dout_rdy=1, 0x0001..0x0008 emerge in order with pop_cnt=8 and err=0.
REQ-033 Streaming: FIFO holds 100 words, dout_rdy=1 -> after fill, one word per cycle, pop_cnt=100.
REQ-034 en drop: deassert en with 2 reads in flight -> both words are delivered and no further fifo_rd occurs until en=1.
REQ-035 Error: pulse fifo_udfl for 1 cycle -> err=1 and stays 1 until rst=0.
REQ-036 Reset: assert rst with occ=3 -> dout_vld=0 and pop_cnt=0 immediately; no stale word appears after release.
